fb_fetch_arbiter: RTL
=====================

# fb_fetch_arbiter

Shares one single-port framebuffer memory between two users:

- **Scanout line prefetch:** hard deadline.
- **Host pixel-write port:** best effort.

The block watches the scan position from the VGA timing generator. During horizontal blanking it fetches the next visible line into a ping-pong line buffer. The timing generator's pixel inputs read from that line buffer. Host writes get the memory only when no fetch is pending or running.

## Interface
Parameters:
- HBITS, 11, column counter width.
- VBITS, 10, row counter width.
- HVISIBLE, 800, words per line.
- VVISIBLE, 600, visible lines.
- VTOTAL, 628, total lines per frame.
- ADDR_BITS, 19, memory word address width.
- DATA_BITS, 24, pixel word width (RGB888).

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  reset; synchronous, active-high (already decided).
- column_addr  in  HBITS  current column from the timing generator.
- row_addr  in  VBITS  current row from the timing generator.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_BITS  word address.
- mem_wdata  out  DATA_BITS  write data.
- mem_ack  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; in order, arbitrary latency ≥1.
- mem_rdata  in  DATA_BITS  read data.
- lb_we  out  1  line-buffer write strobe.
- lb_bank  out  1  line-buffer bank being filled.
- lb_addr  out  HBITS  line-buffer word index.
- lb_wdata  out  DATA_BITS  line-buffer write data.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted this cycle.
- host_addr  in  ADDR_BITS  host write address.
- host_wdata  in  DATA_BITS  host write data.
- busy  out  1  fetch in progress.
- underrun  out  1  sticky; a trigger arrived while a fetch was still in progress.

## Operation
**Trigger.** One trigger cycle occurs when column_addr == HVISIBLE and either condition below holds:
- row_addr < VVISIBLE-1: target line = row_addr+1.
- row_addr == VTOTAL-1: target line = 0.

**Line base address.**
- line_base register, no multiplier.
- Set to 0 on a line-0 trigger; incremented by HVISIBLE on every other trigger.
- All address arithmetic wraps modulo 2^ADDR_BITS.

**Bank.** lb_bank = target line bit 0. It is latched at the trigger and held until the next trigger.

**FSM.**
- **IDLE → ISSUE** on trigger.
  - Issue counter cleared; return counter cleared.
  - busy rises the cycle after the trigger.
- **ISSUE:**
  - mem_req=1, mem_we=0, mem_addr = line_base + issue count.
  - Issue count advances only on mem_ack.
  - After the HVISIBLE-th ack, go to DRAIN.
- **DRAIN:** wait until the return count reaches HVISIBLE, then go to IDLE. busy falls on entry to IDLE.

**Read returns.**
- Accepted in ISSUE and DRAIN.
- Each mem_rvalid drives, on the same cycle: lb_we=1, lb_addr = return count, lb_wdata = mem_rdata. The return count then increments.
- mem_rvalid in IDLE is ignored.

**Host writes.**
- Allowed only in IDLE with no trigger that cycle.
- Drive mem_req = host_valid, mem_we=1, mem_addr/mem_wdata = host_addr/host_wdata.
- host_ready = mem_ack in those cycles; 0 otherwise.
- A host transfer completes when host_valid & host_ready.

**Priority.** Trigger beats host. A host request in the trigger cycle is not accepted and must be held.

**Overlap.** A trigger while not in IDLE is ignored: no restart, current fetch continues, underrun set to 1. underrun clears only on rst.

## Timing
- **Reset values:** mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, lb_we=0, lb_bank=0, lb_addr=0, lb_wdata=0, host_ready=0, busy=0, underrun=0. FSM=IDLE, line_base=0.
- **Reset mid-fetch:** the FSM aborts to IDLE next cycle. Later in-flight mem_rvalid beats are dropped (IDLE rule).
- **Trigger latency:** first fetch request (mem_req=1, mem_we=0) appears the cycle after the trigger cycle.
- **Fetch throughput:** with mem_ack tied high, ISSUE lasts exactly HVISIBLE cycles.
- **Line-buffer latency:** line-buffer writes are combinational from mem_rvalid, with 0 cycles added.
- **Host path:**
  - host_ready is combinational from mem_ack, state and trigger.
  - mem_req/mem_we/mem_addr/mem_wdata are combinational from state and host inputs (no register stage), so host writes sustain one per cycle.
- **Host back-to-back with fetch:** the host write is accepted in the cycle before the trigger; fetch starts the cycle after the trigger.
- **Bank alternation:** consecutive visible lines alternate lb_bank; line 0 always uses bank 0.

## Test plan
Bench parameters: HVISIBLE=8, VVISIBLE=4, VTOTAL=6, HBITS=4, VBITS=3, ADDR_BITS=8, DATA_BITS=8. Memory model returns data = addr with 2-cycle latency.

1. **Basic fetch.** mem_ack=1, row 0, column 8.
   - Reads at addresses 8..15 on consecutive cycles.
   - lb_bank=1; lb_addr 0..7 written with data 8..15.
   - busy high until the last return; underrun stays 0.
2. **Frame wrap.** Row 5, column 8.
   - line_base resets; reads at 0..7; lb_bank=0.
   - Row 3, column 8: no trigger.
3. **Host arbitration.** host_valid held with addr 0x40, data 0x5A.
   - Accepted in IDLE (mem_we=1, addr 0x40).
   - In the trigger cycle: host_ready=0.
   - During ISSUE/DRAIN: host_ready=0.
   - Host write completes the first IDLE cycle after DRAIN.
4. **Backpressure.** mem_ack toggled 1,0,1,0.
   - Addresses advance only on ack; exactly 8 reads issued; DRAIN exits after 8 returns.
5. **Overlap.** mem_ack=0 so the fetch stalls across the next trigger.
   - underrun=1 and stays 1; the fetch is not restarted; issue count continues.
6. **Reset mid-fetch.** rst asserted after 3 reads issued.
   - All outputs return to reset values next cycle; late mem_rvalid beats produce no lb_we.

Source files
------------

// File: rtl/fb_fetch_arbiter_if.sv
// Memory, host-write and line-buffer signals of the framebuffer fetch arbiter.
// master = arbiter side, slave = memory/host/line-buffer side.
interface fb_fetch_arbiter_if #(
  parameter int unsigned HBITS     = 11,
  parameter int unsigned ADDR_BITS = 19,
  parameter int unsigned DATA_BITS = 24
);

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_ack;
  logic                 mem_rvalid;
  logic [DATA_BITS-1:0] mem_rdata;

  logic                 lb_we;
  logic                 lb_bank;
  logic [HBITS-1:0]     lb_addr;
  logic [DATA_BITS-1:0] lb_wdata;

  logic                 host_valid;
  logic                 host_ready;
  logic [ADDR_BITS-1:0] host_addr;
  logic [DATA_BITS-1:0] host_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output lb_we, lb_bank, lb_addr, lb_wdata,
    input  host_valid, host_addr, host_wdata,
    output host_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  lb_we, lb_bank, lb_addr, lb_wdata,
    output host_valid, host_addr, host_wdata,
    input  host_ready
  );

endinterface

// File: rtl/fb_fetch_arbiter.sv
// Shares a single-port framebuffer between scanout line prefetch (hard deadline)
// and host pixel writes (best effort); prefetch fills a ping-pong line buffer.
module fb_fetch_arbiter #(
  parameter int unsigned HBITS     = 11,
  parameter int unsigned VBITS     = 10,
  parameter int unsigned HVISIBLE  = 800,
  parameter int unsigned VVISIBLE  = 600,
  parameter int unsigned VTOTAL    = 628,
  parameter int unsigned ADDR_BITS = 19,
  parameter int unsigned DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HBITS-1:0]     column_addr,
  input  logic [VBITS-1:0]     row_addr,
  fb_fetch_arbiter_if.master   bus,
  output logic                 busy,
  output logic                 underrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [HBITS-1:0]     LINE_WORDS  = HBITS'(HVISIBLE);
  localparam logic [HBITS-1:0]     LAST_WORD   = HBITS'(HVISIBLE - 1);
  localparam logic [VBITS-1:0]     LAST_FETCH  = VBITS'(VVISIBLE - 1);
  localparam logic [VBITS-1:0]     LAST_ROW    = VBITS'(VTOTAL - 1);
  localparam logic [ADDR_BITS-1:0] LINE_STRIDE = ADDR_BITS'(HVISIBLE);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [HBITS-1:0]     issue_cnt;
  logic [HBITS-1:0]     ret_cnt;
  logic [ADDR_BITS-1:0] line_base;
  logic                 bank;

  logic                 wrap_c;
  logic                 trig_c;
  logic                 start_c;
  logic                 ret_en_c;
  logic                 lb_we_c;
  logic                 mem_req_c;
  logic                 mem_we_c;
  logic [ADDR_BITS-1:0] mem_addr_c;
  logic [DATA_BITS-1:0] mem_wdata_c;
  logic                 host_ready_c;

  // One trigger per blanking interval: prefetch the next visible line, or line 0 at frame end.
  assign wrap_c = (row_addr == LAST_ROW);
  assign trig_c = (column_addr == LINE_WORDS) && ((row_addr < LAST_FETCH) || wrap_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the combinational memory/host mux; trigger always beats the host.
  always_comb begin
    state_nxt    = state;
    start_c      = 1'b0;
    ret_en_c     = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    host_ready_c = 1'b0;

    case (state)
      IDLE: begin
        if (trig_c) begin
          start_c   = 1'b1;
          state_nxt = ISSUE;
        end else begin
          mem_req_c    = bus.host_valid;
          mem_we_c     = bus.host_valid;
          mem_addr_c   = bus.host_valid ? bus.host_addr  : '0;
          mem_wdata_c  = bus.host_valid ? bus.host_wdata : '0;
          host_ready_c = bus.mem_ack;
        end
      end
      ISSUE: begin
        ret_en_c   = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = line_base + ADDR_BITS'(issue_cnt);
        if (bus.mem_ack && (issue_cnt == LAST_WORD)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        ret_en_c = 1'b1;
        if (ret_cnt == LINE_WORDS) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read returns go straight into the line buffer in arrival order.
  assign lb_we_c = ret_en_c & bus.mem_rvalid;

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.host_ready = host_ready_c;
  assign bus.lb_we      = lb_we_c;
  assign bus.lb_addr    = lb_we_c ? ret_cnt : '0;
  assign bus.lb_wdata   = lb_we_c ? bus.mem_rdata : '0;
  assign bus.lb_bank    = bank;

  // Fetch bookkeeping; a trigger outside IDLE only raises the sticky underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base <= '0;
      bank      <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (start_c) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        bank      <= wrap_c ? 1'b0 : ~row_addr[0];
        line_base <= wrap_c ? '0 : line_base + LINE_STRIDE;
      end else begin
        if ((state == ISSUE) && bus.mem_ack) begin
          issue_cnt <= issue_cnt + HBITS'(1);
        end
        if (lb_we_c) begin
          ret_cnt <= ret_cnt + HBITS'(1);
        end
      end
      if (trig_c && (state != IDLE)) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule
